// File: rtl/sprite_layer_mux.sv
// Per-pixel fixed-priority sprite overlay for the indexed-colour display path.
// Define COLLISION_EN to build the per-frame sprite-sprite collision reporter.
module sprite_layer_mux #(
   parameter int NUM_SPRITES = 4,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int CW          = 19,
   parameter int IDX_W       = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         pix_valid,
   input  logic                         frame_start,
   input  logic [IDX_W-1:0]             index,
   input  logic [NUM_SPRITES*CW-1:0]    pos_x,
   input  logic [NUM_SPRITES*CW-1:0]    pos_y,
   input  logic [NUM_SPRITES*CW-1:0]    size_w,
   input  logic [NUM_SPRITES*CW-1:0]    size_h,
   input  logic [NUM_SPRITES*IDX_W-1:0] sprite_idx,
   input  logic [NUM_SPRITES-1:0]       sprite_en,
   output logic [IDX_W-1:0]             index_out,
   output logic                         out_valid,
   output logic [NUM_SPRITES-1:0]       hit_mask,
   output logic [NUM_SPRITES-1:0]       collision_mask,
   output logic                         collision_stb
);

   localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

   typedef struct packed {
      logic [CW-1:0]    px;
      logic [CW-1:0]    py;
      logic [CW-1:0]    w;
      logic [CW-1:0]    h;
      logic [IDX_W-1:0] idx;
      logic             en;
   } sprite_t;

   // Hit test in CW+1 bits: the subtraction is only meaningful once x >= px,
   // and the extra bit keeps the rectangle from wrapping past the edges.
   function automatic logic sprite_hit(input sprite_t s,
                                       input logic [CW-1:0] x,
                                       input logic [CW-1:0] y);
      logic [CW:0] dx;
      logic [CW:0] dy;
      dx = {1'b0, x} - {1'b0, s.px};
      dy = {1'b0, y} - {1'b0, s.py};
      return s.en && (x >= s.px) && (dx < {1'b0, s.w})
                  && (y >= s.py) && (dy < {1'b0, s.h});
   endfunction

   // ------------------------------------------------------------------
   // Pixel position counters
   // ------------------------------------------------------------------
   logic [CW-1:0] nxt_x;
   logic [CW-1:0] nxt_y;
   logic [CW-1:0] cur_x;
   logic [CW-1:0] cur_y;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cur_x = nxt_x;
      cur_y = nxt_y;
      if (frame_start) begin
         cur_x = '0;
         cur_y = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nxt_x <= '0;
         nxt_y <= '0;
      end else if (pix_valid) begin
         if (cur_x == X_LAST) begin
            nxt_x <= '0;
            nxt_y <= (cur_y == Y_LAST) ? '0 : cur_y + CW'(1);
         end else begin
            nxt_x <= cur_x + CW'(1);
            nxt_y <= cur_y;
         end
      end
   end

   // ------------------------------------------------------------------
   // Shadow sprite registers, reloaded on the frame_start pixel
   // ------------------------------------------------------------------
   sprite_t shadow [NUM_SPRITES];

   // NOTE: the shadow bank is reset so no sprite is live before the first frame_start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) shadow[i] <= '0;
      end else if (pix_valid && frame_start) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow[i] <= '{px:  pos_x[i*CW +: CW],
                           py:  pos_y[i*CW +: CW],
                           w:   size_w[i*CW +: CW],
                           h:   size_h[i*CW +: CW],
                           idx: sprite_idx[i*IDX_W +: IDX_W],
                           en:  sprite_en[i]};
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: position, background index and valid
   // ------------------------------------------------------------------
   logic             s1_valid;
   logic [CW-1:0]    s1_x;
   logic [CW-1:0]    s1_y;
   logic [IDX_W-1:0] s1_bg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) s1_valid <= 1'b0;
      else       s1_valid <= pix_valid;
   end

   // NOTE: datapath registers carry no reset; s1_valid qualifies every use of them.
   always_ff @(posedge clock) begin
      if (pix_valid) begin
         s1_x  <= cur_x;
         s1_y  <= cur_y;
         s1_bg <= index;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: hit test, priority select, output registers
   // ------------------------------------------------------------------
   logic [NUM_SPRITES-1:0] hit;
   logic [IDX_W-1:0]       sel_idx;

   always_comb begin
      hit     = '0;
      sel_idx = s1_bg;
      for (int i = 0; i < NUM_SPRITES; i++) hit[i] = sprite_hit(shadow[i], s1_x, s1_y);
      // Walk from lowest priority up so sprite 0 has the final say.
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) sel_idx = shadow[i].idx;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         index_out <= '0;
         hit_mask  <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            index_out <= sel_idx;
            hit_mask  <= hit;
         end
      end
   end

   // ------------------------------------------------------------------
   // Collision reporting
   // ------------------------------------------------------------------
`ifdef COLLISION_EN
   logic                   s1_fs;
   logic                   multi_hit;
   logic [NUM_SPRITES-1:0] coll_acc;

   always_ff @(posedge clock) begin
      if (pix_valid) s1_fs <= frame_start;
   end

   always_comb multi_hit = ($countones(hit) >= 2);

   // The frame_start pixel closes the previous frame and opens the next one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         coll_acc       <= '0;
         collision_mask <= '0;
         collision_stb  <= 1'b0;
      end else begin
         collision_stb <= s1_valid && s1_fs;
         if (s1_valid) begin
            if (s1_fs) begin
               collision_mask <= coll_acc;
               coll_acc       <= multi_hit ? hit : '0;
            end else if (multi_hit) begin
               coll_acc <= coll_acc | hit;
            end
         end
      end
   end
`else
   assign collision_mask = '0;
   assign collision_stb  = 1'b0;
`endif

endmodule
